vram_arbiter: RTL and testbench

Shares one single-port, synchronous-read video RAM between the display scan and the game-logic writer. Fetches one framebuffer pixel per `p_tick` inside the visible region and gives every other clock cycle to the writer or to a built-in frame-clear engine. Sits between the VGA sync generator (`p_tick`, `video_on`, `x`, `y`) and the RGB output stage. The framebuffer is stored at reduced resolution and scaled up by pixel replication.

---
 rtl/vram_arbiter_if.sv | 25 ++
 rtl/vram_arbiter.sv | 119 +++++++++++
 tb/tb_vram_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Writer handshake plus RAM port of the VRAM arbiter.
// The arbiter uses the slave modport; the writer/RAM side uses master.
interface vram_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 12
);
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport master (
      output wr_req, wr_addr, wr_data, ram_rdata,
      input  wr_ack, ram_addr, ram_we, ram_wdata
   );

   modport slave (
      input  wr_req, wr_addr, wr_data, ram_rdata,
      output wr_ack, ram_addr, ram_we, ram_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// Shares a single-port VRAM between display scan-out, a frame-clear engine and a writer.
// Define VRAM_CLEAR_EN to build the frame-clear engine; otherwise clr_busy is tied low.
module vram_arbiter #(
   parameter int DATA_W      = 12,
   parameter int FB_W        = 160,
   parameter int FB_H        = 120,
   parameter int SCALE_SHIFT = 2,
   parameter int ADDR_W      = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p_tick,
   input  logic              video_on,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_data,
   output logic              clr_busy,
   output logic [DATA_W-1:0] pixel,
   vram_arbiter_if.slave     bus
);
   localparam int unsigned FB_SIZE = FB_W * FB_H;

   logic              rd_slot;
   logic              rd_pend;
   logic              blank_pend;
   logic              clr_slot;
   logic              wr_in_range;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] clr_addr;
   logic [DATA_W-1:0] clr_val;

   assign rd_slot     = p_tick & video_on;
   assign rd_addr     = ADDR_W'(((32'(y) >> SCALE_SHIFT) * 32'(FB_W)) + (32'(x) >> SCALE_SHIFT));
   assign wr_in_range = 32'(bus.wr_addr) < FB_SIZE;

`ifdef VRAM_CLEAR_EN
   typedef enum logic {IDLE, CLEAR} clr_state_t;
   clr_state_t state;

   // Clear writes only in cycles the display does not claim.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         clr_addr <= '0;
         clr_val  <= '0;
         clr_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clr_start) begin
                  clr_val  <= clr_data;
                  clr_addr <= '0;
                  state    <= CLEAR;
                  clr_busy <= 1'b1;
               end
            end
            CLEAR: begin
               if (!rd_slot) begin
                  if (clr_addr == ADDR_W'(FB_SIZE - 1)) begin
                     state    <= IDLE;
                     clr_busy <= 1'b0;
                  end else begin
                     clr_addr <= clr_addr + ADDR_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign clr_slot = (state == CLEAR) & ~rd_slot;
`else
   logic unused_clr;

   assign unused_clr = ^{clr_start, clr_data};
   assign clr_busy   = 1'b0;
   assign clr_slot   = 1'b0;
   assign clr_addr   = '0;
   assign clr_val    = '0;
`endif

   // Fixed priority: display read > clear > writer.
   always_comb begin
      bus.wr_ack    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      if (rd_slot) begin
         bus.ram_addr = rd_addr;
      end else if (clr_slot) begin
         bus.ram_addr  = clr_addr;
         bus.ram_wdata = clr_val;
         bus.ram_we    = 1'b1;
      end else if (bus.wr_req) begin
         bus.wr_ack    = 1'b1;
         bus.ram_addr  = bus.wr_addr;
         bus.ram_wdata = bus.wr_data;
         bus.ram_we    = wr_in_range;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_pend    <= 1'b0;
         blank_pend <= 1'b0;
         pixel      <= '0;
      end else begin
         rd_pend    <= rd_slot;
         blank_pend <= p_tick & ~video_on;
         if (rd_pend) begin
            pixel <= bus.ram_rdata;
         end else if (blank_pend) begin
            pixel <= '0;
         end
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: arbitration vector table plus read, write,
// blanking, clear and reset sequences against a behavioural synchronous RAM.
module tb_vram_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        p_tick;
   logic        video_on;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        clr_start;
   logic [11:0] clr_data;
   logic        clr_busy;
   logic [11:0] pixel;

   int          errors = 0;
   int          checks = 0;
   int unsigned wr_count = 0;
   logic [11:0] mem [0:32767];

   vram_arbiter_if #(.ADDR_W(15), .DATA_W(12)) bus ();

   vram_arbiter #(
      .DATA_W(12), .FB_W(160), .FB_H(120), .SCALE_SHIFT(2), .ADDR_W(15)
   ) dut (
      .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
      .x(x), .y(y), .clr_start(clr_start), .clr_data(clr_data),
      .clr_busy(clr_busy), .pixel(pixel), .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_wdata;
         wr_count          <= wr_count + 1;
      end
      bus.ram_rdata <= mem[bus.ram_addr];
   end

   typedef struct {
      logic        pt;
      logic        von;
      logic [9:0]  vx;
      logic [9:0]  vy;
      logic        req;
      logic [14:0] waddr;
      logic [11:0] wdata;
      logic        ack;
      logic        we;
      logic [14:0] addr;
   } vec_t;

   vec_t vt [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p_tick      = 1'b0;
      video_on    = 1'b0;
      x           = '0;
      y           = '0;
      bus.wr_req  = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      clr_start   = 1'b0;
      clr_data    = '0;
   endtask

   initial begin
      int unsigned n;
      int unsigned bad;
      int unsigned wc;

      vt[0] = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 15'd0,     12'h000, 1'b0, 1'b0, 15'd0};
      vt[1] = '{1'b1, 1'b1, 10'd4,   10'd4,   1'b1, 15'h10,    12'h123, 1'b0, 1'b0, 15'd161};
      vt[2] = '{1'b1, 1'b1, 10'd0,   10'd0,   1'b0, 15'd0,     12'h000, 1'b0, 1'b0, 15'd0};
      vt[3] = '{1'b1, 1'b1, 10'd639, 10'd479, 1'b0, 15'd0,     12'h000, 1'b0, 1'b0, 15'd19199};
      vt[4] = '{1'b0, 1'b1, 10'd8,   10'd8,   1'b1, 15'h10,    12'h123, 1'b1, 1'b1, 15'h10};
      vt[5] = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b1, 15'd19200, 12'h777, 1'b1, 1'b0, 15'd19200};
      vt[6] = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b1, 15'd19199, 12'h321, 1'b1, 1'b1, 15'd19199};
      vt[7] = '{1'b1, 1'b0, 10'd700, 10'd4,   1'b1, 15'd5,     12'h055, 1'b1, 1'b1, 15'd5};
      vt[8] = '{1'b0, 1'b1, 10'd12,  10'd12,  1'b0, 15'd0,     12'h000, 1'b0, 1'b0, 15'd0};
      vt[9] = '{1'b1, 1'b1, 10'd7,   10'd3,   1'b1, 15'd9,     12'h009, 1'b0, 1'b0, 15'd1};

      idle_inputs();
      reset = 1'b0;
      repeat (3) tick();
      chk("rst_clr_busy", 32'(clr_busy), 32'd0);
      chk("rst_pixel", 32'(pixel), 32'd0);
      chk("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
      chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) begin
         p_tick      = vt[i].pt;
         video_on    = vt[i].von;
         x           = vt[i].vx;
         y           = vt[i].vy;
         bus.wr_req  = vt[i].req;
         bus.wr_addr = vt[i].waddr;
         bus.wr_data = vt[i].wdata;
         #1;
         chk($sformatf("vec%0d_ack", i), 32'(bus.wr_ack), 32'(vt[i].ack));
         chk($sformatf("vec%0d_we", i), 32'(bus.ram_we), 32'(vt[i].we));
         chk($sformatf("vec%0d_addr", i), 32'(bus.ram_addr), 32'(vt[i].addr));
         if (vt[i].we) chk($sformatf("vec%0d_wdata", i), 32'(bus.ram_wdata), 32'(vt[i].wdata));
         tick();
      end
      idle_inputs();
      tick();

      // Preload 161 through the writer, then read it back via scan-out.
      bus.wr_req = 1'b1; bus.wr_addr = 15'd161; bus.wr_data = 12'hABC;
      tick();
      idle_inputs();
      p_tick = 1'b1; video_on = 1'b1; x = 10'd4; y = 10'd4;
      #1;
      chk("read_addr", 32'(bus.ram_addr), 32'd161);
      chk("read_we", 32'(bus.ram_we), 32'd0);
      tick();
      p_tick = 1'b0;
      tick();
      for (int k = 2; k <= 5; k++) begin
         chk($sformatf("read_pixel_T%0d", k), 32'(pixel), 32'hABC);
         tick();
      end

      // Writer held across a read slot is stalled exactly one cycle.
      p_tick = 1'b1; video_on = 1'b1; x = 10'd4; y = 10'd4;
      bus.wr_req = 1'b1; bus.wr_addr = 15'h10; bus.wr_data = 12'h123;
      #1;
      chk("stall_ack_T", 32'(bus.wr_ack), 32'd0);
      tick();
      p_tick = 1'b0;
      #1;
      chk("stall_ack_T1", 32'(bus.wr_ack), 32'd1);
      chk("stall_we_T1", 32'(bus.ram_we), 32'd1);
      chk("stall_addr_T1", 32'(bus.ram_addr), 32'h10);
      tick();
      bus.wr_req = 1'b0;
      chk("stall_mem", 32'(mem[15'h10]), 32'h123);

      // Out-of-range write is acked but dropped.
      wc = wr_count;
      bus.wr_req = 1'b1; bus.wr_addr = 15'd19200; bus.wr_data = 12'hFFF;
      #1;
      chk("oob_ack", 32'(bus.wr_ack), 32'd1);
      chk("oob_we", 32'(bus.ram_we), 32'd0);
      tick();
      bus.wr_req = 1'b0;
      chk("oob_no_write", wr_count, wc);

      // Blanking tick forces pixel to black two cycles later.
      tick();
      p_tick = 1'b1; video_on = 1'b0; x = 10'd700; y = 10'd4;
      #1;
      chk("blank_we", 32'(bus.ram_we), 32'd0);
      chk("blank_addr", 32'(bus.ram_addr), 32'd0);
      tick();
      p_tick = 1'b0;
      chk("blank_pixel_T1", 32'(pixel), 32'hABC);
      tick();
      chk("blank_pixel_T2", 32'(pixel), 32'd0);
      tick();

`ifdef VRAM_CLEAR_EN
      // Clear in vertical blanking, with a same-cycle write in IDLE.
      idle_inputs();
      y = 10'd480;
      clr_start = 1'b1; clr_data = 12'h00F;
      bus.wr_req = 1'b1; bus.wr_addr = 15'h20; bus.wr_data = 12'h456;
      #1;
      chk("clr_same_cycle_ack", 32'(bus.wr_ack), 32'd1);
      tick();
      clr_start = 1'b0;
      bus.wr_addr = 15'h21; bus.wr_data = 12'h789;
      n = 0; bad = 0;
      while (clr_busy && n < 20000) begin
         if (bus.wr_ack) bad++;
         n++;
         tick();
      end
      chk("clr_busy_len", n, 32'd19200);
      chk("clr_writer_stalled", bad, 32'd0);
      chk("clr_ack_after", 32'(bus.wr_ack), 32'd1);
      tick();
      bus.wr_req = 1'b0;
      bad = 0;
      for (int a = 0; a < 19200; a++) begin
         if (a != 'h21 && mem[a] !== 12'h00F) bad++;
      end
      chk("clr_fill_mismatches", bad, 32'd0);
      chk("clr_then_write", 32'(mem[15'h21]), 32'h789);

      // Reset in the middle of a clear aborts it.
      p_tick = 1'b1; video_on = 1'b1; x = 10'd4; y = 10'd4;
      tick();
      p_tick = 1'b0;
      tick();
      chk("pre_rst_pixel", 32'(pixel), 32'h00F);
      clr_start = 1'b1; clr_data = 12'h0A0; y = 10'd480;
      tick();
      clr_start = 1'b0;
      repeat (100) tick();
      reset = 1'b0;
      tick();
      bad = 0;
      wc  = wr_count;
      for (int k = 0; k < 2; k++) begin
         if (bus.ram_we || clr_busy) bad++;
         tick();
      end
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (bus.ram_we || clr_busy) bad++;
         tick();
      end
      chk("midclr_rst_quiet", bad, 32'd0);
      chk("midclr_rst_no_write", wr_count, wc);
      chk("midclr_rst_pixel", 32'(pixel), 32'd0);
      chk("midclr_partial_new", 32'(mem[50]), 32'h0A0);
      chk("midclr_partial_old", 32'(mem[5000]), 32'h00F);
`else
      // Without the clear engine, clr_start is ignored and never stalls the writer.
      clr_start = 1'b1; clr_data = 12'h00F;
      bus.wr_req = 1'b1; bus.wr_addr = 15'h20; bus.wr_data = 12'h456;
      #1;
      chk("noclr_ack0", 32'(bus.wr_ack), 32'd1);
      tick();
      clr_start = 1'b0;
      bus.wr_addr = 15'h21; bus.wr_data = 12'h789;
      #1;
      chk("noclr_busy", 32'(clr_busy), 32'd0);
      chk("noclr_ack1", 32'(bus.wr_ack), 32'd1);
      tick();
      bus.wr_req = 1'b0;
      chk("noclr_mem", 32'(mem[15'h21]), 32'h789);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
